// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver (and the planned transmitter).
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    longint den;
    den = longint'(baud) * longint'(os);
    return int'((longint'(clk_hz) + den / 2) / den);
  endfunction

  function automatic bit params_legal(input int data_bits, input int parity,
                                      input int stop_bits, input int os);
    return (data_bits >= 5) && (data_bits <= 9) && (parity >= 0) && (parity <= 2) &&
           ((stop_bits == 1) || (stop_bits == 2)) && ((os == 8) || (os == 16));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// One-clock tick every DIV clocks; free-running, never resynchronised to the line.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == LAST);
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority, parity/framing/break reporting.
// Define UART_RX_FIFO_EN for a 4-entry output FIFO with data_ready back-pressure.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_M0   = SW'(MID - 1);
  localparam logic [SW-1:0] S_M    = SW'(MID);
  localparam logic [SW-1:0] S_MID1 = SW'(MID + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_START    = ST_START;
  localparam logic [2:0] S_DATA     = ST_DATA;
  localparam logic [2:0] S_PARITY   = ST_PARITY;
  localparam logic [2:0] S_STOP     = ST_STOP;
  localparam logic [2:0] S_BRK_WAIT = ST_BRK_WAIT;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_cfg: clock too slow for BAUD*OVERSAMPLE (DIV < 1)");
  end
  if (!params_legal(DATA_BITS, PARITY, STOP_BITS, OVERSAMPLE)) begin : g_param_check
    $error("uart_rx_cfg: illegal DATA_BITS/PARITY/STOP_BITS/OVERSAMPLE");
  end

  logic tick;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  logic rx_m, rx_s, rx_prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  logic [2:0]           state;
  logic [SW-1:0]        s;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic v0, v1, pbit, perr, ferr, first_stop_low, stop_idx;
  logic maj, at_mid1, at_end, last_stop, cpl, cpl_ferr, cpl_brk;

  assign maj       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign at_mid1   = (s == S_MID1);
  assign at_end    = (s == S_END);
  assign last_stop = (STOP_BITS == 1) || stop_idx;
  assign cpl       = tick && (state == S_STOP) && at_mid1 && last_stop;
  assign cpl_ferr  = ferr | ~maj;
  // Break: all-zero data, zero parity bit (pbit stays 0 without parity), first stop low.
  assign cpl_brk   = (shreg == '0) && !pbit && (stop_idx ? first_stop_low : ~maj);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      s              <= '0;
      idx            <= '0;
      shreg          <= '0;
      v0             <= 1'b1;
      v1             <= 1'b1;
      pbit           <= 1'b0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      first_stop_low <= 1'b0;
      stop_idx       <= 1'b0;
      rx_prev        <= 1'b1;
    end else if (tick) begin
      rx_prev <= rx_s;
      s       <= s + 1'b1;
      if (s == S_M0) v0 <= rx_s;
      if (s == S_M)  v1 <= rx_s;
      case (state)
        S_IDLE: if (rx_prev && !rx_s) begin
          state          <= S_START;
          s              <= '0;
          idx            <= '0;
          pbit           <= 1'b0;
          perr           <= 1'b0;
          ferr           <= 1'b0;
          first_stop_low <= 1'b0;
          stop_idx       <= 1'b0;
        end
        S_START: begin
          if (at_mid1 && maj) state <= S_IDLE;
          else if (at_end)    state <= S_DATA;
        end
        S_DATA: begin
          // LSB-first: after DATA_BITS shifts the first bit sits in shreg[0].
          if (at_mid1) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_mid1) begin
            pbit <= maj;
            perr <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
          end
          if (at_end) state <= S_STOP;
        end
        S_STOP: begin
          if (at_mid1) begin
            if (last_stop) begin
              state <= cpl_brk ? S_BRK_WAIT : S_IDLE;
            end else begin
              ferr           <= cpl_ferr;
              first_stop_low <= ~maj;
            end
          end else if (at_end) begin
            stop_idx <= 1'b1;
          end
        end
        S_BRK_WAIT: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= cpl && cpl_brk;
  end

`ifdef UART_RX_FIFO_EN
  // valid/ready: an entry transfers on any clock where data_valid && data_ready.
  logic [DATA_BITS+1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic pop, full, push_ok;

  assign data_valid = (cnt != 3'd0);
  assign full       = cnt[2];
  assign pop        = data_valid && data_ready;
  assign push_ok    = cpl && (!full || pop);
  assign {data_out, parity_err, frame_err} = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wp] <= {shreg, perr, cpl_ferr};
        wp      <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      cnt         <= cnt + 3'(push_ok) - 3'(pop);
      overrun_err <= cpl && full && !pop;
    end
  end
`else
  logic unused_ready;
  assign unused_ready = data_ready;
  assign overrun_err  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= cpl;
      if (cpl) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= cpl_ferr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: an 8N1 receiver (dut_a) and a 7E2 receiver (dut_b) on separate lines.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0, rst = 1'b1, rx_drv = 1'b1, sel = 1'b0, data_ready = 1'b1;
  logic rx_a, rx_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic a_valid, a_perr, a_ferr, a_brk, a_ovr;
  logic b_valid, b_perr, b_ferr, b_brk, b_ovr;

  assign rx_a = sel ? 1'b1 : rx_drv;
  assign rx_b = sel ? rx_drv : 1'b1;

  uart_rx_cfg #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data_out(a_data), .data_valid(a_valid),
    .data_ready(data_ready), .parity_err(a_perr), .frame_err(a_ferr),
    .break_det(a_brk), .overrun_err(a_ovr));

  uart_rx_cfg #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data_out(b_data), .data_valid(b_valid),
    .data_ready(data_ready), .parity_err(b_perr), .frame_err(b_ferr),
    .break_det(b_brk), .overrun_err(b_ovr));

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard: items are {data[8:0], parity_err, frame_err, break}
  logic [11:0] exp_a[$], exp_b[$];
  logic [11:0] ea, eb;
  int n_vec = 0, n_err = 0;
  int brk_a = 0, brk_b = 0, exp_brk_a = 0, exp_brk_b = 0;
  int ovr_a = 0, exp_ovr_a = 0, n_valid_a = 0;
  int last_va = 0, prev_va = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_brk) brk_a++;
      if (a_ovr) ovr_a++;
      if (a_valid && data_ready) begin
        n_valid_a++;
        prev_va = last_va;
        last_va = cyc;
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_unexpected: got data %0h, no character expected", a_data);
        end else begin
          ea = exp_a.pop_front();
          check("a_data", 32'(a_data), 32'(ea[11:3]));
          check("a_parity_err", 32'(a_perr), 32'(ea[2]));
          check("a_frame_err", 32'(a_ferr), 32'(ea[1]));
`ifndef UART_RX_FIFO_EN
          check("a_break_det", 32'(a_brk), 32'(ea[0]));
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_brk) brk_b++;
      if (b_valid && data_ready) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: got data %0h, no character expected", b_data);
        end else begin
          eb = exp_b.pop_front();
          check("b_data", 32'(b_data), 32'(eb[11:3]));
          check("b_parity_err", 32'(b_perr), 32'(eb[2]));
          check("b_frame_err", 32'(b_ferr), 32'(eb[1]));
`ifndef UART_RX_FIFO_EN
          check("b_break_det", 32'(b_brk), 32'(eb[0]));
`endif
        end
      end
    end
  end

  // drivers (called at a negedge, return at a negedge)
  task automatic drive_bit(input logic b, input int spike_at);
    for (int i = 0; i < 16; i++) begin
      rx_drv = (i == spike_at) ? ~b : b;
      @(negedge clk);
    end
  endtask

  // Reference model: expected result follows from the bits put on the line.
  task automatic send_frame(input bit dut, input logic [8:0] data, input bit flip_par,
                            input bit stop1_low, input bit stop2_low, input int spike_bit,
                            input int gap);
    int nb, par, sb, g;
    logic [8:0] d;
    logic pb, perr, ferr, brk, last_low;
    nb  = dut ? 7 : 8;
    par = dut ? 2 : 0;
    sb  = dut ? 2 : 1;
    d   = data & 9'((1 << nb) - 1);
    pb  = (($countones(d) % 2) == ((par == 1) ? 0 : 1)) ^ flip_par;
    perr = (par != 0) && flip_par;
    ferr = stop1_low || (sb == 2 && stop2_low);
    brk  = (d == 0) && (par == 0 || pb == 1'b0) && stop1_low;
    if (dut == 0) begin
`ifdef UART_RX_FIFO_EN
      if (!data_ready && exp_a.size() >= 4) exp_ovr_a++;
      else exp_a.push_back({d, perr, ferr, brk});
`else
      exp_a.push_back({d, perr, ferr, brk});
`endif
      if (brk) exp_brk_a++;
    end else begin
      exp_b.push_back({d, perr, ferr, brk});
      if (brk) exp_brk_b++;
    end
    sel = dut;
    drive_bit(1'b0, -1);
    for (int i = 0; i < nb; i++) drive_bit(d[i], (i == spike_bit) ? 9 : -1);
    if (par != 0) drive_bit(pb, -1);
    drive_bit(~stop1_low, -1);
    if (sb == 2) drive_bit(~stop2_low, -1);
    last_low = (sb == 1) ? stop1_low : stop2_low;
    g = (last_low && gap < 1) ? 1 : gap;
    for (int i = 0; i < g; i++) drive_bit(1'b1, -1);
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 32'(exp_a.size() + exp_b.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int nv;
    #12;
    check("rst_a_data", 32'(a_data), 0);
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_a_flags", 32'({a_perr, a_ferr, a_brk, a_ovr}), 0);
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_a_state", 32'(dut_a.state), 32'(ST_IDLE));
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);

    // 8N1 back-to-back
    send_frame(0, 9'hA5, 0, 0, 0, -1, 0);
    send_frame(0, 9'h3C, 0, 0, 0, -1, 2);
    wait_drain("b2b");
    check("b2b_spacing", 32'(last_va - prev_va), 160);

    // 7E2 good then flipped parity
    send_frame(1, 9'h41, 0, 0, 0, -1, 0);
    send_frame(1, 9'h41, 1, 0, 0, -1, 1);
    wait_drain("7e2");

    // short glitch on idle line, then mid-bit spikes
    sel = 0; nv = n_valid_a;
    repeat (4) begin rx_drv = 1'b0; @(negedge clk); end
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", 32'(n_valid_a), 32'(nv));
    check("glitch_idle", 32'(dut_a.state), 32'(ST_IDLE));
    send_frame(0, 9'hA5, 0, 0, 0, 2, 1);
    send_frame(0, 9'h5A, 0, 0, 0, 6, 1);
    wait_drain("spike");

    // framing error, then line break
    send_frame(0, 9'h55, 0, 1, 0, -1, 1);
    wait_drain("ferr");
    exp_a.push_back({9'h000, 1'b0, 1'b1, 1'b1});
    exp_brk_a++;
    rx_drv = 1'b0;
    repeat (480) @(negedge clk);
    check("brk_wait_state", 32'(dut_a.state), 32'(ST_BRK_WAIT));
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(0, 9'h96, 0, 0, 0, -1, 1);
    wait_drain("break");
    check("brk_count_a", 32'(brk_a), 32'(exp_brk_a));

    // asynchronous reset in the middle of data bit 4
    sel = 0;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(i[0], -1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", 32'(a_data), 0);
    check("midrst_flags", 32'({a_valid, a_perr, a_ferr, a_brk, a_ovr}), 0);
    check("midrst_state", 32'(dut_a.state), 32'(ST_IDLE));
    rx_drv = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send_frame(0, 9'h5A, 0, 0, 0, -1, 1);
    wait_drain("midrst");

    // randomized traffic on both lines
    for (int n = 0; n < 24; n++) begin
      logic [8:0] d;
      bit sl;
      d  = 9'($urandom_range(0, 255));
      sl = ($urandom_range(0, 99) < 15);
      send_frame(0, d, 0, sl, 0, $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1,
                 $urandom_range(0, 2));
    end
    wait_drain("rand_a");
    for (int n = 0; n < 24; n++) begin
      logic [8:0] d;
      d = 9'($urandom_range(0, 127));
      send_frame(1, d, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0 ? $urandom_range(0, 6) : -1, $urandom_range(0, 2));
    end
    wait_drain("rand_b");
    check("brk_count_a_end", 32'(brk_a), 32'(exp_brk_a));
    check("brk_count_b_end", 32'(brk_b), 32'(exp_brk_b));

`ifdef UART_RX_FIFO_EN
    // fill the FIFO with no consumer, then drain
    @(posedge clk); #1 data_ready = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= 6; n++) send_frame(0, 9'(n), 0, 0, 0, -1, 0);
    repeat (10) @(negedge clk);
    check("fifo_overruns", 32'(ovr_a), 32'(exp_ovr_a));
    check("fifo_full_valid", 32'(a_valid), 1);
    @(posedge clk); #1 data_ready = 1'b1;
    @(negedge clk);
    wait_drain("fifo");
`endif
    check("overrun_total", 32'(ovr_a), 32'(exp_ovr_a));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity, stop-bit count and oversampling.
- 3-sample majority vote per bit; reports parity, framing and break conditions per character.
- Sits between the board RX pin and the command/packet decoder; drop-in for the 8N1 path when DATA_BITS=8, PARITY=0, STOP_BITS=1.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s
DATA_BITS, 8, data bits per character, legal 5..9, sent LSB-first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
OVERSAMPLE, 16, sample ticks per bit, legal 8 or 16

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
data_out  out  DATA_BITS  received character, held until next update
data_valid  out  1  character strobe (see Optional Feature)
data_ready  in  1  consumer accept; used only with the FIFO option
parity_err  out  1  parity mismatch, qualified by data_valid
frame_err  out  1  stop bit sampled low, qualified by data_valid
break_det  out  1  one-cycle pulse on line break
overrun_err  out  1  one-cycle pulse when a character is dropped

Behaviour:
- Reset: clk and rst as above; polarity and asynchronous behaviour are fixed. All flops clear asynchronously. Synchroniser flops reset to 1. data_out = 0; data_valid, parity_err, frame_err, break_det and overrun_err = 0; state = IDLE.
- rx passes through a 2-FF synchroniser to give rx_s. rx_s is also delayed one more tick for edge detection.
- Tick generator: DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded. Emits a one-clk tick every DIV clocks; DIV=1 means a tick every clk. Elaboration error if DIV < 1.
- Tick counter: free-running. It is not reset on a start edge; jitter of ±1 tick is accepted.
- All other state advances only on ticks. The sample counter s runs 0..OVERSAMPLE-1 within a bit. MID = OVERSAMPLE/2.
- Bit value = majority of rx_s at s = MID-1, MID and MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: on rx_s falling edge at a tick, go to START with s = 0.
  - START: at s = MID+1, if majority = 1, treat as a glitch and return to IDLE. At s = OVERSAMPLE-1, go to DATA with bit index 0.
  - DATA: at s = MID+1, shift the majority value into bit[idx]. At s = OVERSAMPLE-1, go to the next bit. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: compare the sampled bit against the expected value. Odd parity: XOR of data bits and parity bit = 1. Even parity: that XOR = 0. Latch perr.
  - STOP: evaluate each stop bit at s = MID+1; any low stop bit sets ferr. The frame completes at MID+1 of the final stop bit, without waiting for the bit end, so the next start edge is not missed. On completion, return to IDLE.
- Completion (the cycle after the final stop-bit evaluation):
  - data_out updates.
  - data_valid pulses with parity_err = perr and frame_err = ferr.
- Break: data all 0, parity bit 0 (if present) and first stop bit 0.
  - Completes as above with frame_err = 1, and break_det pulses in the same cycle.
  - FSM enters BRK_WAIT and stays until rx_s = 1 at a tick, then goes to IDLE. No characters are produced during a break.
- Latency: data_valid is asserted ((1 + DATA_BITS + P + STOP_BITS - 1)*OVERSAMPLE + MID + 2) ticks after the start edge (±1 tick), plus 2 clk for synchronisation. P = 1 if parity is enabled, else 0.
- A falling edge while not in IDLE is ignored.

Optional Feature:
Macro UART_RX_FIFO_EN.
- Defined: a 4-entry FIFO stores {data, parity_err, frame_err}.
  - data_valid = FIFO not empty, and outputs show the head entry. A pop occurs on data_valid && data_ready.
  - Completion while full: the character is dropped and overrun_err pulses.
  - Simultaneous pop and push while full: accepted, no overrun.
  - Break still pulses break_det directly; the break character is also pushed.
- Undefined:
  - data_valid is a one-cycle pulse and data_ready is ignored.
  - data_out, parity_err and frame_err are registered at completion and held.
  - overrun_err is tied 0.

Decomposition:
- Package uart_pkg:
  - parity_e enum (NONE, ODD, EVEN).
  - uart_rx_state_t enum.
  - Function calc_div(clk_hz, baud, os).
  - Elaboration checks for legal parameter ranges.
- Sub-module uart_baud_tick:
  - Parameter DIV; outputs tick.
  - Reused by the planned configurable transmitter.

Test Plan:
Common setup: CLK_HZ = 16_000_000, BAUD = 1_000_000, OVERSAMPLE = 16, so DIV = 1 and one bit = 16 clk.
1. 8N1: send 0xA5 then 0x3C back-to-back (no idle gap) -> data_valid twice with 0xA5 and 0x3C; no error flags; inter-valid spacing 160 clk.
2. 7E2: send 0x41 with correct even parity, then 0x41 with the parity bit flipped -> first character parity_err = 0, second parity_err = 1; data_out = 0x41 both times.
3. Glitch and majority:
   - A 4-clk low pulse on idle rx -> no data_valid, FSM back in IDLE.
   - A 1-clk inverted spike at sample MID inside a data bit -> byte received correctly.
4. Framing and break:
   - Send 0x55 with the stop bit low -> frame_err = 1, break_det = 0.
   - Hold rx low for 30 bit times -> exactly one data_valid with data 0x00, frame_err = 1 and break_det = 1. Next character is accepted only after rx returns high.
5. Reset mid-frame: assert rst asynchronously in DATA at bit 4 -> all outputs 0 immediately; after release, a clean 0x5A is received correctly.
6. With UART_RX_FIFO_EN: hold data_ready = 0 and send 6 characters 0x01..0x06 -> 0x01..0x04 stored; overrun_err pulses twice. Then raise data_ready -> 0x01..0x04 drain in order.
